uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one of four requester bytes at a time to a UART serializer.
// Build option: define UART_TX_ARB_PARITY_EN to derive ser_parity from the data byte.
module uart_tx_arbiter #(
  parameter int PARITY_ODD    = 0,
  parameter int START_TIMEOUT = 4
) (
  input  logic        baud_clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic        err,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        ser_send,
  output logic [7:0]  ser_data,
  output logic        ser_parity,
  input  logic        ser_active,
  input  logic        ser_done
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        ser_send_q, ser_send_d;
  logic [7:0]  ser_data_q, ser_data_d;
  logic        ser_parity_q, ser_parity_d;
  logic [15:0] timer_q, timer_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [7:0]  win_byte;
  logic        win_parity;

  // First requesting index at or above rr_ptr, wrapping modulo 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && req[rr_ptr_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = rr_ptr_q + 2'(i);
      end
    end
  end

  assign win_byte = req_data[{win_idx, 3'b000} +: 8];

`ifdef UART_TX_ARB_PARITY_EN
  assign win_parity = (^win_byte) ^ (PARITY_ODD != 0);
`else
  logic parity_odd_unused;
  assign parity_odd_unused = (PARITY_ODD != 0);
  assign win_parity        = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    ack_d        = 4'b0000;
    err_d        = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    ser_send_d   = 1'b0;
    ser_data_d   = ser_data_q;
    ser_parity_d = ser_parity_q;
    timer_d      = timer_q;

    case (state_q)
      IDLE: begin
        // Holding off while ack is out lets the acked requester drop its level first.
        if (win_found && (ack_q == 4'b0000)) begin
          grant_d      = 4'b0001 << win_idx;
          ser_data_d   = win_byte;
          ser_parity_d = win_parity;
          rr_ptr_d     = win_idx + 2'd1;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: begin
        ser_send_d = 1'b1;
        timer_d    = 16'd0;
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        if (ser_active) begin
          state_d = WAIT_DONE;
        end else if ((int'(timer_q) + 1) >= START_TIMEOUT) begin
          err_d   = 1'b1;
          grant_d = 4'b0000;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      WAIT_DONE: begin
        if (!ser_active && ser_done) begin
          ack_d       = grant_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          grant_d     = 4'b0000;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'd0;
      grant_q      <= 4'b0000;
      ack_q        <= 4'b0000;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_cnt_q  <= 16'd0;
      ser_send_q   <= 1'b0;
      ser_data_q   <= 8'h00;
      ser_parity_q <= 1'b1;
      timer_q      <= 16'd0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      frame_cnt_q  <= frame_cnt_d;
      ser_send_q   <= ser_send_d;
      ser_data_q   <= ser_data_d;
      ser_parity_q <= ser_parity_d;
      timer_q      <= timer_d;
    end
  end

  assign grant      = grant_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;
  assign ser_send   = ser_send_q;
  assign ser_data   = ser_data_q;
  assign ser_parity = ser_parity_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a cycle-stepped serializer model and a behavioural arbitration model.
module tb_uart_tx_arbiter;
  localparam int TMO = 4;

  logic        baud_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic        ser_active = 1'b0;
  logic        ser_done = 1'b1;

  logic [3:0]  grant, ack;
  logic        err, busy, ser_send, ser_parity;
  logic [15:0] frame_cnt;
  logic [7:0]  ser_data;

  logic [3:0]  o_grant, o_ack;
  logic        o_err, o_busy, o_ser_send, o_ser_parity;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_ser_data;

  uart_tx_arbiter #(.PARITY_ODD(0), .START_TIMEOUT(TMO)) dut (
    .baud_clk(baud_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .err(err), .busy(busy), .frame_cnt(frame_cnt),
    .ser_send(ser_send), .ser_data(ser_data), .ser_parity(ser_parity),
    .ser_active(ser_active), .ser_done(ser_done)
  );

  uart_tx_arbiter #(.PARITY_ODD(1), .START_TIMEOUT(TMO)) dut_odd (
    .baud_clk(baud_clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(o_grant), .ack(o_ack), .err(o_err), .busy(o_busy), .frame_cnt(o_frame_cnt),
    .ser_send(o_ser_send), .ser_data(o_ser_data), .ser_parity(o_ser_parity),
    .ser_active(ser_active), .ser_done(ser_done)
  );

  always #5 baud_clk = ~baud_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  int sm_cnt = 0;
  bit sm_busy = 1'b0;
  bit ser_never = 1'b0;
  int ser_delay = 1;
  int ser_len = 1;

  function automatic int pick(logic [3:0] r, int ptr);
    for (int i = 0; i < 4; i++) begin
      if (r[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  // Parity bit that makes the total count of ones even (or odd).
  function automatic logic exp_par(logic [7:0] b, int odd);
`ifdef UART_TX_ARB_PARITY_EN
    int ones;
    ones = $countones(b);
    if (odd != 0) return ((ones % 2) == 0);
    return ((ones % 2) == 1);
`else
    return 1'b1;
`endif
  endfunction

  // Advance to the next falling edge and run the serializer model.
  task automatic step();
    @(negedge baud_clk);
    cyc++;
    if (ser_send && !ser_never && !sm_busy) begin
      sm_busy = 1'b1;
      sm_cnt  = 0;
    end
    if (sm_busy) begin
      sm_cnt++;
      if (sm_cnt == ser_delay) begin
        ser_active = 1'b1;
        ser_done   = 1'b0;
      end
      if (sm_cnt == ser_delay + ser_len) begin
        ser_active = 1'b0;
        ser_done   = 1'b1;
        sm_busy    = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    req_data = 32'h0;
    step();
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
    checks++; if (ser_send !== 1'b0) begin errors++; $display("FAIL reset_ser_send got %b want 0", ser_send); end
    checks++; if (ser_data !== 8'h00) begin errors++; $display("FAIL reset_ser_data got %h want 00", ser_data); end
    checks++; if (ser_parity !== 1'b1) begin errors++; $display("FAIL reset_ser_parity got %b want 1", ser_parity); end
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL reset_idle got busy=%b grant=%b want 0/0000", busy, grant); end
    m_ptr = 0;
    m_cnt = 0;
    $display("reset done");
  endtask

  task automatic test_single();
    int  sends;
    bit  got;
    req_data = $urandom;
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    ser_delay = 2;
    ser_len = 3;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", grant); end
    checks++; if (ser_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", ser_data); end
    checks++; if (ser_parity !== exp_par(8'hA5, 0)) begin errors++; $display("FAIL single_parity got %b want %b", ser_parity, exp_par(8'hA5, 0)); end
    checks++; if (busy !== 1'b1 || ser_send !== 1'b0) begin errors++; $display("FAIL single_launch got busy=%b send=%b want 1/0", busy, ser_send); end
    m_ptr = 1;
    step();
    checks++; if (ser_send !== 1'b1) begin errors++; $display("FAIL single_send got %b want 1", ser_send); end
    sends = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (ser_send) sends++;
      if (ack !== 4'b0000) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL single_ack_timeout got no ack want ack within 40 cycles");
    end else begin
      m_cnt = 1;
      if (ack !== 4'b0001 || frame_cnt !== 16'd1 || grant !== 4'b0000 || sends != 1) begin
        errors++;
        $display("FAIL single_ack got ack=%b cnt=%0d grant=%b sends=%0d want 0001/1/0000/1", ack, frame_cnt, grant, sends);
      end
    end
    $display("single req=0001 data=a5 ack=%b cnt=%0d", ack, frame_cnt);
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_parity();
    bit got;
    req_data = $urandom;
    req_data[7:0] = 8'h07;
    req = 4'b0001;
    ser_delay = 1;
    ser_len = 2;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL parity_grant got %b want 0001", grant); end
    checks++; if (ser_parity !== exp_par(8'h07, 0)) begin errors++; $display("FAIL parity_even got %b want %b", ser_parity, exp_par(8'h07, 0)); end
    checks++; if (o_ser_parity !== exp_par(8'h07, 1)) begin errors++; $display("FAIL parity_odd got %b want %b", o_ser_parity, exp_par(8'h07, 1)); end
    m_ptr = 1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (ack !== 4'b0000) got = 1'b1;
    end
    m_cnt++;
    checks++;
    if (!got || ack !== 4'b0001 || frame_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL parity_ack got ack=%b cnt=%0d want 0001/%0d", ack, frame_cnt, m_cnt);
    end
    $display("parity data=07 even=%b odd=%b", ser_parity, o_ser_parity);
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_random();
    int         w;
    logic [7:0] b;
    bit         got;
    bit         stable;
    req = 4'($urandom_range(1, 15));
    req_data = $urandom;
    for (int f = 0; f < 30; f++) begin
      ser_delay = $urandom_range(1, TMO);
      ser_len = $urandom_range(1, 5);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        step();
        if (grant !== 4'b0000) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL rand_grant_timeout frame %0d got no grant want grant within 20 cycles", f);
        break;
      end
      w = pick(req, m_ptr);
      b = req_data[w*8 +: 8];
      if (grant !== (4'b0001 << w) || ser_data !== b || ser_parity !== exp_par(b, 0) || o_ser_parity !== exp_par(b, 1)) begin
        errors++;
        $display("FAIL rand_grant frame %0d got grant=%b data=%h par=%b/%b want %b/%h/%b/%b", f, grant, ser_data,
                 ser_parity, o_ser_parity, 4'b0001 << w, b, exp_par(b, 0), exp_par(b, 1));
      end
      m_ptr = (w + 1) % 4;
      stable = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        req_data = $urandom;
        if ($urandom_range(0, 3) == 0) req[w] = 1'b0;
        step();
        if (ack !== 4'b0000) got = 1'b1;
        else if (ser_data !== b) stable = 1'b0;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL rand_ack_timeout frame %0d got no ack want ack within 40 cycles", f);
        break;
      end
      m_cnt++;
      if (ack !== (4'b0001 << w) || frame_cnt !== 16'(m_cnt) || grant !== 4'b0000 || !stable) begin
        errors++;
        $display("FAIL rand_ack frame %0d got ack=%b cnt=%0d grant=%b stable=%0d want %b/%0d/0000/1", f, ack, frame_cnt,
                 grant, stable, 4'b0001 << w, m_cnt);
      end
      $display("frame %0d winner=%0d data=%h ack=%b cnt=%0d", f, w, b, ack, frame_cnt);
      req[w] = 1'b0;
      req = req | 4'($urandom_range(0, 15));
      if (req == 4'b0000) req = 4'b0001 << $urandom_range(0, 3);
      req_data = $urandom;
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_timeout();
    int  w0;
    int  w1;
    int  c_send;
    bit  got;
    bit  ack_seen;
    ser_never = 1'b1;
    req = 4'b1111;
    req_data = $urandom;
    w0 = pick(req, m_ptr);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (grant !== 4'b0000) got = 1'b1;
    end
    checks++; if (!got || grant !== (4'b0001 << w0)) begin errors++; $display("FAIL tmo_grant got %b want %b", grant, 4'b0001 << w0); end
    m_ptr = (w0 + 1) % 4;
    got = 1'b0;
    c_send = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      if (ser_send) begin got = 1'b1; c_send = cyc; end
    end
    got = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (ack !== 4'b0000) ack_seen = 1'b1;
      if (err) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL tmo_err_missing got no err want err pulse");
    end else if ((cyc - c_send) != TMO || ack_seen || grant !== 4'b0000 || frame_cnt !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL tmo_err got delay=%0d ack_seen=%0d grant=%b cnt=%0d want %0d/0/0000/%0d", cyc - c_send, ack_seen,
               grant, frame_cnt, TMO, m_cnt);
    end
    $display("timeout winner=%0d err_delay=%0d", w0, cyc - c_send);
    ser_never = 1'b0;
    ser_delay = 1;
    ser_len = 2;
    w1 = pick(req, m_ptr);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (err) ack_seen = 1'b1;
      if (grant !== 4'b0000) got = 1'b1;
    end
    checks++; if (!got || grant !== (4'b0001 << w1)) begin errors++; $display("FAIL tmo_next_grant got %b want %b", grant, 4'b0001 << w1); end
    m_ptr = (w1 + 1) % 4;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (ack !== 4'b0000) got = 1'b1;
    end
    m_cnt++;
    checks++;
    if (!got || ack !== (4'b0001 << w1) || frame_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL tmo_next_ack got ack=%b cnt=%0d want %b/%0d", ack, frame_cnt, 4'b0001 << w1, m_cnt);
    end
    $display("after timeout winner=%0d ack=%b", w1, ack);
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    bit got;
    bit ack_seen;
    ser_delay = 1;
    ser_len = 12;
    req = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (ser_active) got = 1'b1;
    end
    step();
    checks++; if (!got || busy !== 1'b1) begin errors++; $display("FAIL rstmid_setup got active=%0d busy=%b want 1/1", got, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || ack !== 4'b0000 || err !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'h0000 ||
        ser_send !== 1'b0 || ser_data !== 8'h00 || ser_parity !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_outputs got grant=%b ack=%b err=%b busy=%b cnt=%h send=%b data=%h par=%b want 0000/0000/0/0/0000/0/00/1",
               grant, ack, err, busy, frame_cnt, ser_send, ser_data, ser_parity);
    end
    ack_seen = 1'b0;
    step();
    step();
    ser_active = 1'b0;
    ser_done = 1'b1;
    sm_busy = 1'b0;
    ser_len = 2;
    req = 4'b1111;
    rst_n = 1'b1;
    m_ptr = 0;
    m_cnt = 0;
    $display("reset mid-frame released");
    for (int r = 0; r < 4; r++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        step();
        if (r == 0 && (ack !== 4'b0000 || err !== 1'b0)) ack_seen = 1'b1;
        if (grant !== 4'b0000) got = 1'b1;
      end
      checks++; if (!got || grant !== (4'b0001 << r)) begin errors++; $display("FAIL rr_grant %0d got %b want %b", r, grant, 4'b0001 << r); end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        step();
        if (ack !== 4'b0000) got = 1'b1;
      end
      m_cnt++;
      checks++;
      if (!got || ack !== (4'b0001 << r) || frame_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rr_ack %0d got ack=%b cnt=%0d want %b/%0d", r, ack, frame_cnt, 4'b0001 << r, m_cnt);
      end
      $display("rr frame %0d grant=%b ack=%b", r, 4'b0001 << r, ack);
    end
    checks++; if (ack_seen) begin errors++; $display("FAIL rstmid_no_ack got ack/err after reset want none"); end
    m_ptr = 0;
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_wrap();
    int          n;
    int          acks;
    bit          got;
    logic [15:0] prev_cnt;
    logic [15:0] last_cnt;
    ser_delay = 1;
    ser_len = 1;
    req = 4'b1111;
    n = 65536 - m_cnt;
    acks = 0;
    prev_cnt = 16'h1234;
    last_cnt = 16'h1234;
    for (int f = 0; f < n; f++) begin
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        step();
        if (ack !== 4'b0000) got = 1'b1;
      end
      if (!got) break;
      acks++;
      prev_cnt = last_cnt;
      last_cnt = frame_cnt;
    end
    req = 4'b0000;
    checks++; if (acks != n) begin errors++; $display("FAIL wrap_acks got %0d want %0d", acks, n); end
    checks++; if (prev_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_before got %h want ffff", prev_cnt); end
    checks++; if (last_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_after got %h want 0000", last_cnt); end
    $display("wrap frames=%0d final cnt=%h", acks, last_cnt);
    step();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_random();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
